// File: rtl/banked_sp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : banked_sp_ram_pkg
// Description : Shared types and address-decode helpers for banked_sp_ram.
//               The helpers take the geometry as arguments because a package
//               cannot see the parameters of the module that imports it.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package banked_sp_ram_pkg;

  // Controller state: zero-fill sweep, then normal access
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Geometry of the default build
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_ROWS   = 4;
  localparam int DEF_ROW_WORDS  = 2048;
  localparam int DEF_BYTES      = DEF_DATA_WIDTH / 8;
  localparam int DEF_ROW_BITS   = $clog2(DEF_NUM_ROWS);
  localparam int DEF_COL_BITS   = $clog2(DEF_ROW_WORDS);
  localparam int DEF_TOTAL_WORDS = DEF_NUM_ROWS * DEF_ROW_WORDS;

  // Row index of a word address: the bits directly above the column field
  function automatic int unsigned addr_to_row(input logic [31:0] word,
                                              input int unsigned col_bits,
                                              input int unsigned num_rows);
    logic [31:0] mask;
    mask = num_rows - 1;
    return (word >> col_bits) & mask;
  endfunction

  // Column (word within row) of a word address
  function automatic int unsigned addr_to_col(input logic [31:0] word,
                                              input int unsigned row_words);
    logic [31:0] mask;
    mask = row_words - 1;
    return word & mask;
  endfunction

  // A word address is valid only inside the populated rows
  function automatic logic addr_in_range(input logic [31:0] word,
                                         input int unsigned total_words);
    return (word < total_words);
  endfunction

endpackage : banked_sp_ram_pkg
`default_nettype wire

// File: rtl/ST_SPHDL_2048x8m8_L.sv
`default_nettype none
// ============================================================================
// Module      : ST_SPHDL_2048x8m8_L
// Description : Behavioural stand-in for the 2048x8 single-port SRAM macro,
//               pin-compatible with the library cell (CSN/WEN active low,
//               one-cycle read latency, Q holds when not read). Replaced by
//               the technology cell in the physical flow.
// Revision    : 1.0 - initial release
// ============================================================================
module ST_SPHDL_2048x8m8_L (
  input  logic        CK,
  input  logic        CSN,
  input  logic        WEN,
  input  logic [10:0] A,
  input  logic [7:0]  D,
  output logic [7:0]  Q,
  input  logic        TBYPASS
);

  logic [7:0] mem [2048];

  // Synchronous access; bypass routes D straight to Q for macro test
  always_ff @(posedge CK) begin
    if (!CSN) begin
      if (TBYPASS) begin
        Q <= D;
      end else if (!WEN) begin
        mem[A] <= D;
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule : ST_SPHDL_2048x8m8_L
`default_nettype wire

// File: rtl/sram_bank_row.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank_row
// Description : One bank row, DATA_WIDTH/8 byte lanes sharing chip select
//               and address, each lane with its own active-low write enable.
//               Uses the 2048x8 macro for 2048-word rows, a behavioural
//               array for any other depth.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bank_row #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_WORDS  = 2048,
  parameter int BYTES      = DATA_WIDTH / 8,
  parameter int AW         = $clog2(ROW_WORDS)
) (
  input  logic                  clk,
  input  logic                  csn_i,
  input  logic [BYTES-1:0]      wen_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  tbypass_i
);

  if (ROW_WORDS == 2048) begin : g_macro
    for (genvar j = 0; j < BYTES; j++) begin : g_lane
      ST_SPHDL_2048x8m8_L u_macro (
        .CK      (clk),
        .CSN     (csn_i),
        .WEN     (wen_i[j]),
        .A       (addr_i),
        .D       (wdata_i[j*8 +: 8]),
        .Q       (rdata_o[j*8 +: 8]),
        .TBYPASS (tbypass_i)
      );
    end
  end else begin : g_behav
    logic [DATA_WIDTH-1:0] mem [ROW_WORDS];

    // Per-lane write or read, same timing as the macro
    always_ff @(posedge clk) begin
      if (!csn_i) begin
        for (int j = 0; j < BYTES; j++) begin
          if (tbypass_i) begin
            rdata_o[j*8 +: 8] <= wdata_i[j*8 +: 8];
          end else if (!wen_i[j]) begin
            mem[addr_i][j*8 +: 8] <= wdata_i[j*8 +: 8];
          end else begin
            rdata_o[j*8 +: 8] <= mem[addr_i][j*8 +: 8];
          end
        end
      end
    end
  end

endmodule : sram_bank_row
`default_nettype wire

// File: rtl/banked_sp_ram.sv
`default_nettype none
// ============================================================================
// Module      : banked_sp_ram
// Description : Banked single-port RAM with req/gnt/rvalid handshake,
//               out-of-range error response and post-reset zero-fill sweep.
//               Optional macro BANKED_SP_RAM_OUT_REG_EN adds an output
//               register after the row mux (response latency 2 instead of 1).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module banked_sp_ram
  import banked_sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 15,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_ROWS      = 4,
  parameter int ROW_WORDS     = 2048,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  input  logic                    bypass_i,
  output logic                    init_done_o
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int OFF_BITS    = $clog2(BYTES);
  localparam int COL_BITS    = $clog2(ROW_WORDS);
  localparam int ROW_BITS    = $clog2(NUM_ROWS);
  localparam int ROW_IDX_W   = (ROW_BITS > 0) ? ROW_BITS : 1;
  localparam int TOTAL_WORDS = NUM_ROWS * ROW_WORDS;

  localparam state_e RST_STATE     = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
  localparam logic   RST_INIT_DONE = (INIT_ON_RESET != 0) ? 1'b0 : 1'b1;
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(ROW_WORDS - 1);

  // Controller and response state
  state_e                state_q, state_d;
  logic [COL_BITS-1:0]   cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  rvalid1_q, rvalid1_d;
  logic                  err1_q, err1_d;
  logic                  rd1_q, rd1_d;
  logic [ROW_IDX_W-1:0]  row1_q, row1_d;

  // Address decode and access qualification
  logic [31:0]           word_w;
  logic [ROW_IDX_W-1:0]  row_w;
  logic [COL_BITS-1:0]   col_w;
  logic                  in_range_w;
  logic                  gnt_w;
  logic                  acc_w;

  // Shared macro-side buses
  logic [NUM_ROWS-1:0]   csn_w;
  logic [BYTES-1:0]      mac_wen_w;
  logic [COL_BITS-1:0]   mac_addr_w;
  logic [DATA_WIDTH-1:0] mac_wdata_w;
  logic [DATA_WIDTH-1:0] row_rdata_w [NUM_ROWS];
  logic [DATA_WIDTH-1:0] q_mux_w;
  logic [DATA_WIDTH-1:0] resp_data_w;

  assign word_w     = 32'(addr_i) >> OFF_BITS;
  assign row_w      = ROW_IDX_W'(addr_to_row(word_w, COL_BITS, NUM_ROWS));
  assign col_w      = COL_BITS'(addr_to_col(word_w, ROW_WORDS));
  assign in_range_w = addr_in_range(word_w, TOTAL_WORDS);
  assign gnt_w      = (state_q == ST_READY);
  assign acc_w      = req_i & gnt_w;
  assign gnt_o      = gnt_w;
  assign init_done_o = init_done_q;

  // Sweep counter and INIT -> READY transition after exactly ROW_WORDS cycles
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_COL) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      ST_READY: ;
      default: state_d = ST_INIT;
    endcase
  end

  // Macro controls: sweep writes zeros to every row, otherwise one row per access
  always_comb begin
    csn_w       = '1;
    mac_addr_w  = col_w;
    mac_wdata_w = wdata_i;
    mac_wen_w   = ~(be_i & {BYTES{we_i}});
    if (state_q == ST_INIT) begin
      csn_w       = '0;
      mac_addr_w  = cnt_q;
      mac_wdata_w = '0;
      mac_wen_w   = '0;
    end else begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        if (acc_w && in_range_w && (row_w == ROW_IDX_W'(i))) begin
          csn_w[i] = 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    sram_bank_row #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_WORDS  (ROW_WORDS)
    ) u_row (
      .clk       (clk),
      .csn_i     (csn_w[i]),
      .wen_i     (mac_wen_w),
      .addr_i    (mac_addr_w),
      .wdata_i   (mac_wdata_w),
      .rdata_o   (row_rdata_w[i]),
      .tbypass_i (bypass_i)
    );
  end

  // First response stage: remembers what kind of access was accepted and which row
  always_comb begin
    rvalid1_d = acc_w;
    err1_d    = acc_w & ~in_range_w;
    rd1_d     = acc_w & ~we_i & in_range_w;
    row1_d    = acc_w ? row_w : row1_q;
  end

  // Row mux driven by the registered row index; writes and errors return zero
  always_comb begin
    q_mux_w = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (row1_q == ROW_IDX_W'(i)) begin
        q_mux_w = row_rdata_w[i];
      end
    end
    resp_data_w = rd1_q ? q_mux_w : '0;
  end

`ifdef BANKED_SP_RAM_OUT_REG_EN
  logic                  rvalid2_q, rvalid2_d;
  logic                  err2_q, err2_d;
  logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;

  // Output register stage; data only updates on a response so it holds otherwise
  always_comb begin
    rvalid2_d = rvalid1_q;
    err2_d    = err1_q;
    rdata2_d  = rvalid1_q ? resp_data_w : rdata2_q;
  end

  assign rvalid_o = rvalid2_q;
  assign err_o    = err2_q;
  assign rdata_o  = rdata2_q;
`else
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  // Keeps the last response data visible between responses
  always_comb begin
    hold_d = rvalid1_q ? resp_data_w : hold_q;
  end

  assign rvalid_o = rvalid1_q;
  assign err_o    = err1_q;
  assign rdata_o  = rvalid1_q ? resp_data_w : hold_q;
`endif

  // All controller and response flops; reset restarts the sweep and drops responses
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      init_done_q <= RST_INIT_DONE;
      rvalid1_q   <= 1'b0;
      err1_q      <= 1'b0;
      rd1_q       <= 1'b0;
      row1_q      <= '0;
`ifdef BANKED_SP_RAM_OUT_REG_EN
      rvalid2_q   <= 1'b0;
      err2_q      <= 1'b0;
      rdata2_q    <= '0;
`else
      hold_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rvalid1_q   <= rvalid1_d;
      err1_q      <= err1_d;
      rd1_q       <= rd1_d;
      row1_q      <= row1_d;
`ifdef BANKED_SP_RAM_OUT_REG_EN
      rvalid2_q   <= rvalid2_d;
      err2_q      <= err2_d;
      rdata2_q    <= rdata2_d;
`else
      hold_q      <= hold_d;
`endif
    end
  end

endmodule : banked_sp_ram
`default_nettype wire

// File: tb/tb_banked_sp_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_banked_sp_ram
// Description : Directed self-checking bench for banked_sp_ram (ADDR_WIDTH=16
//               so that 0x8000 is an out-of-range address).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banked_sp_ram;

`ifdef BANKED_SP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic [15:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        bypass_i;
  logic        init_done_o;

  int n_cmp = 0;
  int n_err = 0;

  // Burst description: one entry per request, with the expected response
  logic        b_we   [8];
  logic [15:0] b_addr [8];
  logic [3:0]  b_be   [8];
  logic [31:0] b_wd   [8];
  logic [31:0] b_expd [8];
  logic        b_expe [8];
  logic [31:0] last_d;

  banked_sp_ram #(
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (32),
    .NUM_ROWS      (4),
    .ROW_WORDS     (2048),
    .INIT_ON_RESET (1)
  ) dut (
    .clk         (clk),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .bypass_i    (bypass_i),
    .init_done_o (init_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic w, input logic [15:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        input logic [31:0] ed, input logic ee);
    b_we[i] = w; b_addr[i] = a; b_be[i] = b; b_wd[i] = d;
    b_expd[i] = ed; b_expe[i] = ee;
  endtask

  // Issue n back-to-back requests from a negedge and check each response LAT cycles later
  task automatic run_burst(input int n, input string tag);
    for (int t = 0; t < n + LAT + 1; t++) begin
      if (t >= LAT && (t - LAT) < n) begin
        chk($sformatf("%s[%0d].rvalid", tag, t - LAT), {31'b0, rvalid_o}, 32'd1);
        chk($sformatf("%s[%0d].rdata", tag, t - LAT), rdata_o, b_expd[t - LAT]);
        chk($sformatf("%s[%0d].err", tag, t - LAT), {31'b0, err_o}, {31'b0, b_expe[t - LAT]});
        last_d = b_expd[t - LAT];
      end else begin
        chk($sformatf("%s.idle%0d", tag, t), {31'b0, rvalid_o}, 32'd0);
        if (t == n + LAT) chk($sformatf("%s.hold", tag), rdata_o, last_d);
      end
      if (t < n) begin
        req_i = 1'b1; we_i = b_we[t]; addr_i = b_addr[t]; be_i = b_be[t]; wdata_i = b_wd[t];
      end else begin
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
      end
      @(negedge clk);
    end
  endtask

  // Count cycles from reset release until grant appears; no response may appear meanwhile
  task automatic wait_init(input string tag);
    int n = 0;
    int spur = 0;
    while (gnt_o !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
      if (rvalid_o !== 1'b0) spur++;
    end
    chk({tag, ".cycles"}, 32'(n), 32'd2048);
    chk({tag, ".spurious_rvalid"}, 32'(spur), 32'd0);
    chk({tag, ".init_done"}, {31'b0, init_done_o}, 32'd1);
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0;
    wdata_i = '0; bypass_i = 1'b0; last_d = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst.gnt", {31'b0, gnt_o}, 32'd0);
    chk("rst.rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("rst.rdata", rdata_o, 32'd0);
    chk("rst.err", {31'b0, err_o}, 32'd0);
    chk("rst.init_done", {31'b0, init_done_o}, 32'd0);

    rst_ni = 1'b1;
    wait_init("init1");

    // Zero-filled contents at first and last word
    set_op(0, 1'b0, 16'h0000, 4'h0, 32'h0, 32'h0000_0000, 1'b0);
    set_op(1, 1'b0, 16'h7FFC, 4'h0, 32'h0, 32'h0000_0000, 1'b0);
    run_burst(2, "zero_rd");

    // Write then read-after-write on the next cycle (row 1, col 1)
    set_op(0, 1'b1, 16'h2004, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
    set_op(1, 1'b0, 16'h2004, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    run_burst(2, "raw");

    // Partial byte-enable write over existing data, then be=0 no-op write
    set_op(0, 1'b1, 16'h6008, 4'hF, 32'hAABB_CCDD, 32'h0, 1'b0);
    set_op(1, 1'b1, 16'h6008, 4'b0101, 32'h1122_3344, 32'h0, 1'b0);
    set_op(2, 1'b0, 16'h6008, 4'h0, 32'h0, 32'hAA22_CC44, 1'b0);
    set_op(3, 1'b1, 16'h6008, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    set_op(4, 1'b0, 16'h6008, 4'h0, 32'h0, 32'hAA22_CC44, 1'b0);
    run_burst(5, "be");

    // Distinct values in each row, then back-to-back reads across rows
    set_op(0, 1'b1, 16'h0000, 4'hF, 32'h1010_1010, 32'h0, 1'b0);
    set_op(1, 1'b1, 16'h2000, 4'hF, 32'h2020_2020, 32'h0, 1'b0);
    set_op(2, 1'b1, 16'h4000, 4'hF, 32'h3030_3030, 32'h0, 1'b0);
    set_op(3, 1'b1, 16'h6000, 4'hF, 32'h4040_4040, 32'h0, 1'b0);
    run_burst(4, "row_wr");
    set_op(0, 1'b0, 16'h0000, 4'h0, 32'h0, 32'h1010_1010, 1'b0);
    set_op(1, 1'b0, 16'h2000, 4'h0, 32'h0, 32'h2020_2020, 1'b0);
    set_op(2, 1'b0, 16'h4000, 4'h0, 32'h0, 32'h3030_3030, 1'b0);
    set_op(3, 1'b0, 16'h6000, 4'h0, 32'h0, 32'h4040_4040, 1'b0);
    run_burst(4, "row_rd");

    // Out of range write and read; the dropped write must not alias onto word 0
    set_op(0, 1'b1, 16'h8000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
    set_op(1, 1'b0, 16'h8000, 4'h0, 32'h0, 32'h0, 1'b1);
    set_op(2, 1'b0, 16'h0000, 4'h0, 32'h0, 32'h1010_1010, 1'b0);
    run_burst(3, "oor");

    // Reset while a response is pending drops it and restarts the sweep
    req_i = 1'b1; we_i = 1'b0; addr_i = 16'h2004;
    @(posedge clk);
    #1;
    rst_ni = 1'b0; req_i = 1'b0; addr_i = '0;
    #1;
    chk("rst_drop.rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("rst_drop.gnt", {31'b0, gnt_o}, 32'd0);
    chk("rst_drop.init_done", {31'b0, init_done_o}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    wait_init("init2");
    set_op(0, 1'b0, 16'h2004, 4'h0, 32'h0, 32'h0000_0000, 1'b0);
    run_burst(1, "cleared");

    // Reset in the middle of the sweep restarts the full sweep
    set_op(0, 1'b1, 16'h4000, 4'hF, 32'h5555_AAAA, 32'h0, 1'b0);
    run_burst(1, "pre_mid");
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (1000) @(negedge clk);
    chk("mid.gnt", {31'b0, gnt_o}, 32'd0);
    rst_ni = 1'b0;
    #1;
    chk("mid.init_done", {31'b0, init_done_o}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    wait_init("init3");
    set_op(0, 1'b0, 16'h4000, 4'h0, 32'h0, 32'h0000_0000, 1'b0);
    run_burst(1, "mid_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_banked_sp_ram
`default_nettype wire

// File: doc/banked_sp_ram.md
Name: banked_sp_ram

Overview:
- Parametrised successor to the fixed 4-row x 4-byte-lane single-port SRAM wrapper.
- Row count, row depth and data width are generic.
- Adds a req/gnt/rvalid handshake, an out-of-range error response and a post-reset zero-fill sweep.
- Sits between the core/accelerator data port and the technology SRAM macros; one access per cycle once initialised.

Parameters:
- ADDR_WIDTH, 15: byte-address width; must be >= log2(NUM_ROWS*ROW_WORDS*DATA_WIDTH/8).
- DATA_WIDTH, 32: word width; multiple of 8.
- NUM_ROWS, 4: number of bank rows; power of two, >= 1.
- ROW_WORDS, 2048: words per row; power of two.
- INIT_ON_RESET, 1: 1 = zero-fill all rows after reset; 0 = ready immediately, contents undefined.

Ports:
- clk  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  access request
- gnt_o  out  1  request accepted this cycle
- addr_i  in  ADDR_WIDTH  byte address; word-aligned, low log2(DATA_WIDTH/8) bits ignored
- we_i  in  1  1 = write, 0 = read
- be_i  in  DATA_WIDTH/8  byte enables for writes
- wdata_i  in  DATA_WIDTH  write data
- rvalid_o  out  1  response valid, one per granted request
- rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors
- err_o  out  1  out-of-range access, qualified by rvalid_o
- bypass_i  in  1  macro test bypass (TBYPASS), passed to all macros
- init_done_o  out  1  zero-fill complete

Behaviour:
- Clocking/reset: single clock clk; rst_ni is asynchronous, active-low.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, init_done_o=0 (1 if INIT_ON_RESET=0). FSM to INIT (READY if INIT_ON_RESET=0). Sweep counter 0.
- Address split: word = addr_i >> log2(DATA_WIDTH/8); col = word[log2(ROW_WORDS)-1:0]; row = word[log2(ROW_WORDS)+:log2(NUM_ROWS)]. Out of range: word >= NUM_ROWS*ROW_WORDS.
- FSM INIT:
  - gnt_o=0.
  - Each cycle, all rows are written in parallel: all byte enables, data 0, address = counter.
  - Counter increments each cycle. At ROW_WORDS-1 the FSM goes to READY next cycle, init_done_o=1.
  - Duration is exactly ROW_WORDS cycles after reset release.
- FSM READY:
  - gnt_o = 1, combinationally, regardless of req_i.
  - A request is accepted on req_i & gnt_o; only the selected row's chip select is active (active-low CSN). Idle cycles: all CSN high.
  - Write: byte lane j written iff be_i[j]. be_i=0 is a legal no-op write that still gets a response.
- Response:
  - rvalid_o is asserted exactly 1 cycle after every accepted request (latency 1); no backpressure.
  - Back-to-back requests give back-to-back rvalid_o.
  - Read data is muxed by the row index registered at acceptance.
  - Write response: rdata_o=0, err_o=0.
  - Out-of-range: no macro is enabled; writes are dropped; response has rdata_o=0, err_o=1.
  - Read-after-write to the same address on consecutive cycles returns the new data.
- rdata_o holds its last value when rvalid_o=0; consumers must qualify with rvalid_o.
- Reset mid-INIT or mid-READY: FSM restarts INIT, the sweep restarts from 0 and any pending rvalid_o is dropped.

Optional Feature:
- Macro: BANKED_SP_RAM_OUT_REG_EN.
- Defined:
  - Adds an output register stage after the row mux; read/write response latency becomes 2 cycles.
  - rvalid_o and err_o are pipelined identically.
  - Throughput stays 1 access per cycle.
  - Reset clears the stage.
- Undefined: latency 1 as described above.

Decomposition:
- Package banked_sp_ram_pkg:
  - state enum (INIT, READY).
  - Localparams: BYTES = DATA_WIDTH/8, ROW_BITS, COL_BITS, TOTAL_WORDS.
  - Functions: addr_to_row, addr_to_col, addr_in_range.
- Sub-module sram_bank_row: one row of DATA_WIDTH/8 byte-wide ST_SPHDL_2048x8m8_L macros, with CSN/WEN/A/D/Q/TBYPASS and per-lane write enable.
- For ROW_WORDS != 2048, sram_bank_row instantiates a behavioural array instead (generate branch).
- Top level holds the FSM, sweep counter, response pipeline and row mux.

Test Plan:
- Reset, INIT_ON_RESET=1 -> gnt_o=0 for exactly 2048 cycles. Then init_done_o=1, gnt_o=1. Read 0x0000, 0x7FFC -> rdata_o=0x00000000, err_o=0.
- Write 0x2004 data 0xDEADBEEF, be=0xF; next cycle read 0x2004 -> rvalid_o 1 cycle after each request; read returns 0xDEADBEEF (row 1, col 1).
- Write 0x6008 data 0x11223344, be=0b0101, over existing 0xAABBCCDD -> read returns 0xAA22CC44.
- Back-to-back reads of 0x0000, 0x2000, 0x4000, 0x6000 holding distinct values -> 4 consecutive rvalid_o cycles, each with the correct row data (registered row mux).
- ADDR_WIDTH=16, read and write 0x8000 -> err_o=1, rdata_o=0. Subsequent read of 0x0000 is unchanged.
- Assert rst_ni low at sweep count 1000, release -> full 2048-cycle INIT repeats, with no spurious rvalid_o. With BANKED_SP_RAM_OUT_REG_EN defined, rerun the read-after-write test -> latency 2 cycles.
